image_reader: RTL and testbench
===============================

# image_reader

Streaming read-out engine that sits directly downstream of the single-port image RAM. On a `start` pulse it sweeps RAM addresses 0 to DEPTH-1 in order. It absorbs the RAM's one-cycle registered read latency and presents pixels on a valid/ready stream with full backpressure support. It owns the RAM port only while `busy` is high; the top level muxes the port between this block and the loader.

## Interface
Parameters:
- `DATA_WIDTH`, 8, pixel width; must match the RAM.
- `ADDRESS_WIDTH`, 8, RAM address width.
- `DEPTH`, 256, number of pixels per frame; 2 ≤ DEPTH ≤ 2^ADDRESS_WIDTH.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- `abort`  in  1  cancel the current frame; takes priority over all other events.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse after the last pixel handshake.
- `ram_wEn`  out  1  constant 0; this block never writes.
- `ram_addr`  out  ADDRESS_WIDTH  registered read address.
- `ram_data`  in  DATA_WIDTH  RAM read data, valid one cycle after `ram_addr` is sampled.
- `pix_data`  out  DATA_WIDTH  pixel value, taken from the FIFO head.
- `pix_valid`  out  1  high when the FIFO is non-empty.
- `pix_ready`  in  1  downstream accept.
- `pix_last`  out  1  high with the final pixel of the frame.

## Operation
States and transitions:
- **IDLE:** on `start`, issue a read of address 0 and go to RUN.
- **RUN:** issue one read per cycle while a credit is available. After issuing address DEPTH-1, go to DRAIN.
- **DRAIN:** issue nothing. Go to IDLE when the last pixel handshakes (`pix_valid & pix_ready & pix_last`).

Read pipeline and buffering:
- An issue registers `ram_addr` and sets in-flight stage s0.
- s0 advances to s1 on the next edge, when the RAM samples the address.
- While s1 is set, `ram_data` is pushed into a 4-entry output FIFO at the following edge.
- Each FIFO entry carries a `last` tag, set for the address DEPTH-1 read.

Credit rule:
- Issue only if `fifo_count + s0 + s1 < 4`, using current-cycle values and ignoring a same-cycle pop.
- This rule means the FIFO can never overflow.
- With `pix_ready` held high, steady state is count=1 plus two reads in flight, giving one pixel per cycle.

Stream and control rules:
- Pop on `pix_valid & pix_ready`.
- Push and pop in the same cycle leave the count unchanged.
- `pix_data` and `pix_last` stay stable while `pix_valid` is high and `pix_ready` is low.
- The address counter is ADDRESS_WIDTH wide and never wraps: issuing stops at DEPTH-1.
- `start` while busy is ignored; it does not restart or queue.
- `abort` in any state: at the next edge, empty the FIFO, clear s0 and s1, and go to IDLE. `done` does not pulse. `start` and `abort` in the same cycle: `abort` wins and the block stays IDLE.
- `rst_n` low at any time, including mid-frame, immediately forces IDLE, clears the FIFO and pipeline, and drops all outputs to their reset values.

## Timing
- Reset values: `busy`=0, `done`=0, `ram_wEn`=0, `ram_addr`=0, `pix_valid`=0, `pix_last`=0, `pix_data`=0.
- Start-to-data latency: `start` sampled at edge E0, so `ram_addr`=0 and `busy`=1 after E0. The RAM captures at E1. The FIFO pushes at E2, so `pix_valid` is high after E2.
- Uninterrupted frame: DEPTH consecutive valid cycles, with `pix_last` high on the DEPTH-th.
- `done` is registered: it goes high in the cycle after the last handshake, lasts one cycle, and coincides with `busy` falling.
- Earliest restart: a `start` in the `done` cycle is accepted, since the state is already IDLE.
- Backpressure: at most 4 pixels are fetched ahead of the consumer. After `pix_ready` rises, data resumes the same cycle from the FIFO.

## Test plan
- **Reset:** assert `rst_n`=0 asynchronously between edges → all outputs 0 immediately; `busy`=0 after release.
- **Full-rate frame:** DEPTH=16 RAM preloaded with data = 0xA0+addr, `pix_ready`=1 → first `pix_valid` 2 cycles after `start`; data 0xA0..0xAF on 16 consecutive cycles; `pix_last` only on 0xAF; `done` one cycle later.
- **Backpressure:** `pix_ready` low for cycles 3–12, then random toggling → no loss, duplication or reordering; `pix_data` stable while stalled; `ram_addr` never more than 4 ahead of the pixel count accepted.
- **Start while busy:** pulse `start` mid-frame and again in the DRAIN state → ignored; exactly one frame of 16 pixels and one `done`.
- **Abort:** `abort` after 5 pixels accepted → `pix_valid`=0 and `busy`=0 next cycle, no `done`; a following `start` delivers 0xA0 first.
- **Reset mid-frame:** `rst_n` low during RUN with FIFO occupancy 3 → FIFO empty, IDLE; the next frame is complete and correct.

Source files
------------

// File: rtl/image_reader.sv
// image_reader
// Streaming read-out engine for the single-port image RAM. A start pulse
// sweeps addresses 0..DEPTH-1 once. The block absorbs the RAM's one-cycle
// registered read latency and buffers pixels in a 4-entry FIFO. The FIFO
// drives a valid/ready stream that supports full backpressure.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a frame (honoured only when idle)
//   abort      cancel the current frame (highest priority)
//   busy       frame in progress (RUN or DRAIN)
//   done       one-cycle pulse after the last pixel handshake
//   ram_wEn    RAM write enable, always 0
//   ram_addr   registered RAM read address
//   ram_data   RAM read data, one cycle after ram_addr is sampled
//   pix_data   pixel at the FIFO head (0 when no pixel is valid)
//   pix_valid  FIFO non-empty
//   pix_ready  downstream accept
//   pix_last   final pixel of the frame
module image_reader #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DEPTH         = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_wEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0]    ram_data,
  output logic [DATA_WIDTH-1:0]    pix_data,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic                     pix_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  logic [1:0]               state;
  logic                     vld_p0, vld_p1;
  logic                     last_p0, last_p1;
  logic [DATA_WIDTH-1:0]    fifo_data [4];
  logic [3:0]               fifo_last;
  logic [1:0]               wr_ptr, rd_ptr;
  logic [2:0]               count;

  logic [3:0]               inflight;
  logic                     credit;
  logic                     issue;
  logic [ADDRESS_WIDTH-1:0] issue_addr;
  logic                     issue_last;
  logic                     push, pop, last_hs;

  // Reads in flight count against the FIFO space. A pop in the same cycle
  // is deliberately ignored, so the FIFO can never overflow.
  always_comb begin
    inflight   = {1'b0, count} + {3'b000, vld_p0} + {3'b000, vld_p1};
    credit     = (inflight < 4'd4);
    issue      = 1'b0;
    issue_addr = ram_addr;
    case (state)
      S_IDLE: begin
        if (start) begin
          issue      = 1'b1;
          issue_addr = '0;
        end
      end
      S_RUN: begin
        if (credit) begin
          issue      = 1'b1;
          issue_addr = ram_addr + ADDRESS_WIDTH'(1);
        end
      end
      default: ;
    endcase
    if (abort) issue = 1'b0;
    issue_last = (issue_addr == LAST_ADDR);
  end

  assign pix_valid = (count != 3'd0);
  assign pop       = pix_valid & pix_ready;
  assign push      = vld_p1;
  assign last_hs   = pop & fifo_last[rd_ptr];

  assign busy      = (state != S_IDLE);
  assign ram_wEn   = 1'b0;
  // Gated by pix_valid so the un-reset FIFO storage never leaks to the port.
  assign pix_data  = pix_valid ? fifo_data[rd_ptr] : '0;
  assign pix_last  = pix_valid & fifo_last[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ram_addr <= '0;
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      last_p0  <= 1'b0;
      last_p1  <= 1'b0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      done     <= 1'b0;
    end else if (abort) begin
      state    <= S_IDLE;
      ram_addr <= '0;
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      last_p0  <= 1'b0;
      last_p1  <= 1'b0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      done     <= 1'b0;
    end else begin
      done <= last_hs & (state == S_DRAIN);

      // p0: address registered toward the RAM
      if (issue) ram_addr <= issue_addr;
      vld_p0  <= issue;
      last_p0 <= issue & issue_last;

      // p1: RAM has sampled the address; its data is on ram_data
      vld_p1  <= vld_p0;
      last_p1 <= last_p0;

      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push} - {2'b00, pop};

      case (state)
        S_IDLE:  if (start) state <= S_RUN;
        S_RUN:   if (issue && issue_last) state <= S_DRAIN;
        S_DRAIN: if (last_hs) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage: only the pointers above are reset
  always_ff @(posedge clk) begin
    if (push && !abort) begin
      fifo_data[wr_ptr] <= ram_data;
      fifo_last[wr_ptr] <= last_p1;
    end
  end

endmodule

// File: tb/tb_image_reader.sv
module tb_image_reader;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam logic [AW-1:0] LASTA = AW'(DEPTH - 1);

  logic clk, rst_n, start, abort, busy, done, ram_wEn, pix_valid, pix_ready, pix_last;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data, pix_data;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_q [$];

  typedef struct {
    bit            ready;
    bit            valid;
    logic [DW-1:0] data;
    bit            last;
    bit            done;
    bit            busy;
  } vec_t;
  vec_t tbl [20];

  image_reader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy),
    .done(done), .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_data(ram_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_last(pix_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM
  always @(posedge clk) ram_data <= mem[ram_addr];

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_wen"}, ram_wEn, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_valid"}, pix_valid, 0);
    chk({tag, "_last"}, pix_last, 0);
    chk({tag, "_data"}, pix_data, 0);
  endtask

  // mode 0: ready always high; 1: ready low for cycles 3..12 then random;
  // 2: random ready. Expected pixels come from the RAM image in order.
  task automatic run_frame(input int mode, input bit inject, input bit skip_start, input bit chain);
    int acc = 0;
    int cyc = 0;
    bit prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    bit prev_last = 0;
    bit inj_d = 0;
    bit r;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(mem[i]);
    if (!skip_start) begin
      @(negedge clk);
      start = 1'b1;
      pix_ready = 1'b0;
    end
    while (acc < DEPTH && cyc < 2000) begin
      @(negedge clk);
      start = 1'b0;
      if (skip_start && cyc == 0) begin
        chk("restart_busy", busy, 1);
        chk("restart_addr", ram_addr, 0);
      end
      cyc++;
      if (prev_stall) begin
        chk("stall_valid", pix_valid, 1);
        chk("stall_data", pix_data, prev_data);
        chk("stall_last", pix_last, prev_last);
      end
      chk("no_early_done", done, 0);
      if (busy) chk("fetch_ahead_le4", ((int'(ram_addr) + 1 - acc) <= 4), 1);
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc >= 3 && cyc <= 12) ? 1'b0 : 1'($urandom_range(0, 1));
        default: r = 1'($urandom_range(0, 1));
      endcase
      pix_ready = r;
      if (inject && cyc == 5) start = 1'b1;
      if (inject && !inj_d && busy && ram_addr == LASTA) begin
        start = 1'b1;
        inj_d = 1'b1;
      end
      if (pix_valid && r) begin
        chk("pix_data", pix_data, exp_q[0]);
        chk("pix_last", pix_last, (exp_q.size() == 1));
        void'(exp_q.pop_front());
        acc++;
      end
      prev_stall = pix_valid && !r;
      prev_data  = pix_data;
      prev_last  = pix_last;
    end
    chk("frame_complete", acc, DEPTH);
    @(negedge clk);
    start = 1'b0;
    pix_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_fall", busy, 0);
    chk("valid_after", pix_valid, 0);
    if (chain) begin
      start = 1'b1;
    end else begin
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_after", busy, 0);
    end
  endtask

  initial begin
    int acc, n;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(8'hA0 + i);
    for (int k = 0; k < 20; k++) begin
      tbl[k].ready = 1'b1;
      tbl[k].valid = (k >= 2 && k <= 17);
      tbl[k].data  = tbl[k].valid ? DW'(8'hA0 + k - 2) : '0;
      tbl[k].last  = (k == 17);
      tbl[k].done  = (k == 18);
      tbl[k].busy  = (k <= 17);
    end

    rst_n = 1'b1; start = 1'b0; abort = 1'b0; pix_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_valid", pix_valid, 0);

    // Full-rate frame against the cycle table
    pix_ready = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      pix_ready = tbl[k].ready;
      if (k == 0) chk("tbl_first_addr", ram_addr, 0);
      chk($sformatf("tbl_valid_%0d", k), pix_valid, tbl[k].valid);
      chk($sformatf("tbl_data_%0d", k), pix_data, tbl[k].data);
      chk($sformatf("tbl_last_%0d", k), pix_last, tbl[k].last);
      chk($sformatf("tbl_done_%0d", k), done, tbl[k].done);
      chk($sformatf("tbl_busy_%0d", k), busy, tbl[k].busy);
      chk($sformatf("tbl_wen_%0d", k), ram_wEn, 0);
    end

    run_frame(1, 0, 0, 0);   // backpressure window then random
    run_frame(0, 1, 0, 0);   // start pulses mid-frame and in DRAIN
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_second_frame", busy, 0);
      chk("no_second_done", done, 0);
    end

    // Abort after 5 accepted pixels
    @(negedge clk);
    start = 1'b1; pix_ready = 1'b1;
    acc = 0; n = 0;
    while (acc < 5 && n < 50) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (pix_valid) begin
        chk("abort_pre_data", pix_data, 8'hA0 + acc);
        acc++;
      end
    end
    chk("abort_pre_count", acc, 5);
    @(negedge clk);
    abort = 1'b1; pix_ready = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", pix_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_stays_empty", pix_valid, 0);
    end
    run_frame(0, 0, 0, 0);   // restart delivers 0xA0 first

    // start and abort together: abort wins
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    @(negedge clk);
    chk("start_abort_valid", pix_valid, 0);
    chk("start_abort_busy2", busy, 0);

    // Reset mid-frame with FIFO holding 3 pixels
    @(negedge clk);
    start = 1'b1; pix_ready = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("midreset_pre_valid", pix_valid, 1);
    chk("midreset_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_idle", busy, 0);
    chk("midreset_empty", pix_valid, 0);
    run_frame(2, 0, 0, 0);

    // Start in the done cycle is accepted
    run_frame(0, 0, 0, 1);
    run_frame(2, 0, 1, 0);

    // Randomized RAM contents and ready patterns
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      run_frame(2, f[0], 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
